// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive-side byte packer.
//   pack_state_e : packer FSM state (IDLE = no partial word, COLLECT = partial)
//   word_w()     : packed word width from byte width and bytes per word
//   idx_w()      : width of the byte index inside a word
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } pack_state_e;

  function automatic int word_w(input int bits, input int nbytes);
    return bits * nbytes;
  endfunction

  // Keep at least one bit so a degenerate configuration still elaborates.
  function automatic int idx_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/uart_word_fifo2.sv
// -----------------------------------------------------------------------------
// uart_word_fifo2
// Two-entry in-order word buffer between the packer and the word consumer.
// A push into a full buffer is accepted only if a pop happens in the same
// cycle; otherwise it is dropped and the stored contents stay untouched.
//
// Ports:
//   clk       in   clock, rising edge
//   rstN      in   asynchronous active-low reset (clears storage to 0)
//   push      in   request to store pushData
//   pushData  in   WIDTH-bit word to store
//   pop       in   request to remove the head word (ignored when empty)
//   headData  out  WIDTH-bit word at the head of the buffer
//   accept    out  push taken this cycle
//   full      out  both entries occupied
//   empty     out  no entries occupied
// -----------------------------------------------------------------------------
module uart_word_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             accept,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign do_pop   = pop && !empty;
  // When full, wr_ptr equals rd_ptr, so a same-cycle pop frees exactly the
  // slot the push writes into.
  assign do_push  = push && (!full || do_pop);
  assign accept   = do_push;
  assign headData = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= pushData;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_packer.sv
// -----------------------------------------------------------------------------
// uart_rx_packer
// Packs WORD_BYTES consecutive received bytes (LSB first) into one word and
// hands completed words to a 2-entry buffer with a valid/ready interface.
// A byte flagged with a framing error throws away the partial word.
//
// Optional feature (macro UART_RX_PACKER_TIMEOUT_EN): a partial word that sees
// no new byte for TIMEOUT cycles is discarded and timeoutPulse fires for one
// cycle. Without the macro a partial word waits indefinitely and the
// timeoutPulse port does not exist.
//
// Ports:
//   clk           in   clock, rising edge
//   rstN          in   asynchronous active-low reset
//   rxData        in   received byte, qualified by rxValid
//   rxValid       in   one-cycle strobe for rxData/rxError
//   rxError       in   framing error for the byte in this strobe
//   clrErr        in   synchronous clear of the sticky flags
//   wordData      out  head-of-buffer word
//   wordValid     out  buffer non-empty
//   wordReady     in   consumer takes the head word when wordValid&wordReady
//   frameErr      out  sticky: a byte arrived with rxError=1
//   overrun       out  sticky: a completed word was dropped (buffer full)
//   busy          out  partial word in progress
//   timeoutPulse  out  (macro only) partial word discarded by timeout
// -----------------------------------------------------------------------------
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int WORD_BYTES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [BITS-1:0]            rxData,
  input  logic                       rxValid,
  input  logic                       rxError,
  input  logic                       clrErr,
  output logic [BITS*WORD_BYTES-1:0] wordData,
  output logic                       wordValid,
  input  logic                       wordReady,
  output logic                       frameErr,
  output logic                       overrun,
  output logic                       busy
`ifdef UART_RX_PACKER_TIMEOUT_EN
  ,
  output logic                       timeoutPulse
`endif
);

  localparam int WORD_W = word_w(BITS, WORD_BYTES);
  localparam int IDX_W  = idx_w(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  if (WORD_BYTES < 2 || TIMEOUT < 1) begin : g_param_check
    $error("uart_rx_packer: WORD_BYTES must be >= 2 and TIMEOUT >= 1");
  end

  pack_state_e       state;
  pack_state_e       state_nxt;
  logic [IDX_W-1:0]  byte_idx;
  logic [IDX_W-1:0]  byte_idx_nxt;
  logic [WORD_W-1:0] asm_word;
  logic [WORD_W-1:0] asm_word_nxt;
  logic [IDX_W-1:0]  base_idx;
  logic [WORD_W-1:0] base_word;

  logic              good_byte;
  logic              bad_byte;
  logic              to_hit;

  logic              push_vld_p0;
  logic [WORD_W-1:0] push_word_p0;
  logic              fifo_accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign good_byte = rxValid && !rxError;
  assign bad_byte  = rxValid && rxError;

  // A timeout that coincides with a new byte discards the old partial word
  // first, so the new byte starts a fresh word instead of being lost.
  assign base_idx  = to_hit ? '0 : byte_idx;
  assign base_word = to_hit ? '0 : asm_word;

  always_comb begin
    state_nxt    = to_hit ? IDLE : state;
    byte_idx_nxt = base_idx;
    asm_word_nxt = base_word;
    push_vld_p0  = 1'b0;
    push_word_p0 = base_word;
    push_word_p0[int'(base_idx)*BITS +: BITS] = rxData;

    if (bad_byte) begin
      state_nxt    = IDLE;
      byte_idx_nxt = '0;
      asm_word_nxt = '0;
    end else if (good_byte) begin
      if (base_idx == LAST_IDX) begin
        push_vld_p0  = 1'b1;
        state_nxt    = IDLE;
        byte_idx_nxt = '0;
        asm_word_nxt = '0;
      end else begin
        state_nxt    = COLLECT;
        byte_idx_nxt = base_idx + IDX_W'(1);
        asm_word_nxt = push_word_p0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      byte_idx <= '0;
      asm_word <= '0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
      asm_word <= asm_word_nxt;
    end
  end

  // Sticky flags: a set event in the same cycle as clrErr wins.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (bad_byte) begin
        frameErr <= 1'b1;
      end else if (clrErr) begin
        frameErr <= 1'b0;
      end
      if (push_vld_p0 && !fifo_accept) begin
        overrun <= 1'b1;
      end else if (clrErr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PACKER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;

  assign to_hit       = (state == COLLECT) && (to_cnt == TO_W'(TIMEOUT));
  assign timeoutPulse = to_hit;

  // Counts idle cycles of a partial word; any byte restarts the count.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      to_cnt <= '0;
    end else if ((state == COLLECT) && !rxValid && !to_hit) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // ---- stage p0 -> output buffer ----
  assign pop       = wordValid && wordReady;
  assign wordValid = !fifo_empty;
  assign busy      = (byte_idx != '0);

  uart_word_fifo2 #(
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk      (clk),
    .rstN     (rstN),
    .push     (push_vld_p0),
    .pushData (push_word_p0),
    .pop      (pop),
    .headData (wordData),
    .accept   (fifo_accept),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_packer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_packer
// Directed scenarios followed by randomized traffic, all compared against a
// queue-based model of bytes-in-progress, buffered words and sticky flags.
// Define UART_RX_PACKER_TIMEOUT_EN to also exercise the idle timeout
// (TIMEOUT=16 in that build).
// -----------------------------------------------------------------------------
module tb_uart_rx_packer;

  localparam int BITS = 8;
  localparam int WB   = 4;
`ifdef UART_RX_PACKER_TIMEOUT_EN
  localparam int TO   = 16;
`else
  localparam int TO   = 1024;
`endif

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic [BITS-1:0] rxData = '0;
  logic            rxValid = 1'b0;
  logic            rxError = 1'b0;
  logic            clrErr = 1'b0;
  logic            wordReady = 1'b0;
  logic [31:0]     wordData;
  logic            wordValid;
  logic            frameErr;
  logic            overrun;
  logic            busy;
`ifdef UART_RX_PACKER_TIMEOUT_EN
  logic            timeoutPulse;
`endif

  uart_rx_packer #(
    .BITS       (BITS),
    .WORD_BYTES (WB),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .rxError   (rxError),
    .clrErr    (clrErr),
    .wordData  (wordData),
    .wordValid (wordValid),
    .wordReady (wordReady),
    .frameErr  (frameErr),
    .overrun   (overrun),
    .busy      (busy)
`ifdef UART_RX_PACKER_TIMEOUT_EN
    ,
    .timeoutPulse (timeoutPulse)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  m_part[$];
  logic [31:0] m_buf[$];
  bit          m_fe;
  bit          m_ov;
  int          m_idle;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_part.delete();
    m_buf.delete();
    m_fe   = 1'b0;
    m_ov   = 1'b0;
    m_idle = 0;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_edge();
    bit          fe_set;
    bit          ov_set;
    logic [31:0] w;
    fe_set = 1'b0;
    ov_set = 1'b0;
    if (m_buf.size() > 0 && wordReady) void'(m_buf.pop_front());
`ifdef UART_RX_PACKER_TIMEOUT_EN
    if (m_part.size() > 0 && m_idle == TO) m_part.delete();
`endif
    if (rxValid) begin
      if (rxError) begin
        m_part.delete();
        fe_set = 1'b1;
      end else begin
        m_part.push_back(rxData);
        if (m_part.size() == WB) begin
          w = '0;
          for (int i = 0; i < WB; i++) w = w | (32'(m_part[i]) << (8 * i));
          m_part.delete();
          if (m_buf.size() < 2) m_buf.push_back(w);
          else ov_set = 1'b1;
        end
      end
    end
    if (rxValid || m_part.size() == 0) m_idle = 0;
    else m_idle++;
    m_fe = fe_set ? 1'b1 : (clrErr ? 1'b0 : m_fe);
    m_ov = ov_set ? 1'b1 : (clrErr ? 1'b0 : m_ov);
  endtask

  task automatic compare();
    chk("wordValid", wordValid, m_buf.size() > 0);
    if (m_buf.size() > 0) chk("wordData", wordData, m_buf[0]);
    chk("busy", busy, m_part.size() != 0);
    chk("frameErr", frameErr, m_fe);
    chk("overrun", overrun, m_ov);
`ifdef UART_RX_PACKER_TIMEOUT_EN
    chk("timeoutPulse", timeoutPulse, (m_part.size() > 0) && (m_idle == TO));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    rxValid = 1'b1;
    rxData  = b;
    rxError = err;
    step();
    rxValid = 1'b0;
    rxError = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < WB; i++) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wordData"}, wordData, 32'h0);
    chk({tag, "_wordValid"}, wordValid, 1'b0);
    chk({tag, "_frameErr"}, frameErr, 1'b0);
    chk({tag, "_overrun"}, overrun, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    // Power-on reset
    rstN = 1'b0;
    #3;
    check_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    model_reset();

    // Basic packing, LSB first
    wordReady = 1'b1;
    send_byte(8'h11, 1'b0);
    chk("busy_first", busy, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    chk("valid_early", wordValid, 1'b0);
    send_byte(8'h44, 1'b0);
    chk("valid_lat1", wordValid, 1'b1);
    chk("word_basic", wordData, 32'h44332211);
    chk("busy_done", busy, 1'b0);

    // Framing error drops the partial word
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    chk("fe_set", frameErr, 1'b1);
    chk("busy_after_err", busy, 1'b0);
    send_word(32'h04030201);
    chk("word_after_err", wordData, 32'h04030201);
    step();

    // Overrun with consumer stalled
    wordReady = 1'b0;
    clrErr = 1'b1;
    step();
    clrErr = 1'b0;
    chk("fe_clr", frameErr, 1'b0);
    send_word(32'h31211101);
    send_word(32'h32221202);
    send_word(32'h33231303);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_head1", wordData, 32'h31211101);
    wordReady = 1'b1;
    step();
    chk("ovr_head2", wordData, 32'h32221202);
    step();
    chk("ovr_drained", wordValid, 1'b0);
    clrErr = 1'b1;
    step();
    clrErr = 1'b0;
    chk("ovr_clr", overrun, 1'b0);

    // Full buffer: push and pop in the same cycle
    wordReady = 1'b0;
    send_word(32'hA3A2A1A0);
    send_word(32'hB3B2B1B0);
    send_byte(8'hC0, 1'b0);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    wordReady = 1'b1;
    send_byte(8'hC3, 1'b0);
    chk("simul_no_ovr", overrun, 1'b0);
    chk("simul_head", wordData, 32'hB3B2B1B0);
    step();
    chk("simul_next", wordData, 32'hC3C2C1C0);
    step();

    // Reset in the middle of a word; strobes during reset are ignored
    send_byte(8'h5A, 1'b0);
    send_byte(8'h5B, 1'b0);
    rstN    = 1'b0;
    rxValid = 1'b1;
    rxData  = 8'h99;
    #2;
    check_zero("midrst");
    @(posedge clk);
    #1;
    check_zero("midrst_hold");
    rxValid = 1'b0;
    rstN    = 1'b1;
    model_reset();
    send_word(32'h0D0C0B0A);
    chk("word_post_rst", wordData, 32'h0D0C0B0A);
    step();

`ifdef UART_RX_PACKER_TIMEOUT_EN
    // Idle timeout discards the partial word
    send_byte(8'h77, 1'b0);
    repeat (TO) step();
    chk("to_pulse", timeoutPulse, 1'b1);
    step();
    chk("to_pulse_end", timeoutPulse, 1'b0);
    chk("to_busy", busy, 1'b0);
    send_word(32'h87868584);
    chk("word_post_to", wordData, 32'h87868584);
    step();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rxValid   = ($urandom_range(0, 1) == 1);
      rxError   = ($urandom_range(0, 15) == 0);
      rxData    = 8'($urandom);
      wordReady = ($urandom_range(0, 2) != 0);
      clrErr    = ($urandom_range(0, 31) == 0);
      step();
    end
    rxValid = 1'b0;
    rxError = 1'b0;
    clrErr  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
